error_monitor: RTL and testbench
================================

ERROR_MONITOR -- requirements
Module: error_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of error, MSE and thresholds.
REQ-002 SHALL have parameter FRAC, default 20, fractional bits of all fixed-point values.
REQ-003 SHALL have parameter WIN_LOG2, default 6, log2 of the MSE window length in samples.
REQ-004 SHALL have parameter HYST, default 4, consecutive windows required to enter or leave CONVERGED.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 i_valid  in  1  i_error/i_ovr qualify this cycle.
REQ-008 i_error  in  WIDTH signed  filter error sample, Q(FRAC).
REQ-009 i_ovr  in  1  upstream overflow flag for this sample.
REQ-010 i_clear  in  1  single-cycle request to restart monitoring.
REQ-011 i_conv_thresh  in  WIDTH unsigned  convergence MSE threshold.
REQ-012 i_div_thresh  in  WIDTH unsigned  divergence MSE threshold.
REQ-013 o_mse  out  WIDTH unsigned  last completed window MSE.
REQ-014 o_mse_valid  out  1  one-cycle pulse when o_mse updates.
REQ-015 o_state  out  2  0=ACQUIRE, 1=CONVERGED, 2=DIVERGED.
REQ-016 o_ovr_count  out  16  saturating count of accepted samples with i_ovr=1.

Function
REQ-017 Accepted sample: i_valid=1 at a rising edge; no state changes otherwise.
REQ-018 Square stage: sq = (i_error*i_error) full 2*WIDTH signed product, arithmetic shift right FRAC, saturate to WIDTH-bit unsigned all-ones; registered, 1 cycle.
REQ-019 Accumulate stage: WIDTH+WIN_LOG2-bit accumulator adds sq; a window is 2^WIN_LOG2 accepted samples.
REQ-020 Window end: o_mse = acc >> WIN_LOG2 (truncate), o_mse_valid pulses, acc restarts from 0 with no lost sample.
REQ-021 Latency: o_mse_valid high in the cycle after the second rising edge following acceptance of the window's last sample.
REQ-022 Window ovr flag set if any sample in the window had i_ovr=1.
REQ-023 Thresholds sampled at window evaluation; pass = mse < i_conv_thresh and no ovr; fail_div = mse > i_div_thresh or ovr (equality neither converges nor diverges).
REQ-024 ACQUIRE -> CONVERGED after HYST consecutive pass windows; non-pass window resets the run count.
REQ-025 CONVERGED -> ACQUIRE after HYST consecutive non-pass windows.
REQ-026 ACQUIRE or CONVERGED -> DIVERGED on any fail_div window (priority over REQ-024/025).
REQ-027 DIVERGED held until i_clear; then ACQUIRE.
REQ-028 i_clear (any state, any time): zero acc, window sample counter, pipeline, run counter, ovr flag; state ACQUIRE; o_mse and o_ovr_count retained; sample accepted with i_clear discarded.
REQ-029 i_clear coinciding with window end: clear wins, no o_mse_valid pulse.
REQ-030 o_ovr_count saturates at 16'hFFFF, never wraps; cleared only by rst.

Reset
REQ-031 rst SHALL set o_mse=0, o_mse_valid=0, o_state=ACQUIRE, o_ovr_count=0 and zero all internal counters, accumulator and pipeline registers; reset mid-window discards the partial window.

Structure
REQ-032 Package error_monitor_pkg SHALL hold the state enum (ACQUIRE, CONVERGED, DIVERGED) and the 16-bit counter width constant.
REQ-033 Sub-module err_square SHALL implement REQ-018 (registered square, shift, saturate); FSM, accumulator and counters stay in error_monitor.

Verification (WIDTH=32, FRAC=20, WIN_LOG2=2, HYST=2)
REQ-034 8 samples i_error=0x00080000 (0.5), conv_thresh=0x00100000, div_thresh=0x00A00000 -> two o_mse_valid pulses, o_mse=0x00040000, o_state=CONVERGED after second.
REQ-035 Then 4 samples i_error=0xFFC00000 (-4.0) -> o_mse=0x01000000, o_state=DIVERGED; i_clear -> ACQUIRE.
REQ-036 i_error=0x7FFFFFFF for 4 samples -> o_mse=0xFFFFFFFF (saturated square), DIVERGED.
REQ-037 4 samples of 0.5 with i_ovr=1 on sample 2 -> o_ovr_count=1, DIVERGED despite low MSE.
REQ-038 i_valid toggling every other cycle -> same o_mse as REQ-034; i_clear on window-end cycle -> no pulse, state ACQUIRE.
REQ-039 rst asserted after 3 samples -> all outputs zero, next window needs 4 fresh samples.

Source files
------------

// File: rtl/error_monitor_pkg.sv
// Shared types and constants for the error monitor.
package error_monitor_pkg;
  typedef enum logic [1:0] {
    ACQUIRE   = 2'd0,
    CONVERGED = 2'd1,
    DIVERGED  = 2'd2
  } state_t;

  // Width of the overflow counter and the hysteresis run counter.
  localparam int CNT_W = 16;
endpackage

// File: rtl/error_monitor_square.sv
// Registered square of a fixed-point error sample, rescaled back to Q(FRAC)
// and saturated to WIDTH-bit unsigned.
module err_square #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] error,
  output logic        [WIDTH-1:0] sq
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      sat;

  // A square is never negative, so any set bit above WIDTH means overflow.
  assign prod    = error * error;
  assign shifted = prod >>> FRAC;
  assign sat     = |shifted[2*WIDTH-1:WIDTH];

  // Square register; flushed by reset and by a monitoring restart.
  always_ff @(posedge clk) begin
    if (rst || clear)
      sq <= '0;
    else if (en)
      sq <= sat ? '1 : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/error_monitor.sv
// Windowed MSE monitor with convergence/divergence tracking.
// Pipeline: accept+square -> accumulate (window close) -> evaluate/output.
module error_monitor
  import error_monitor_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 20,
  parameter int WIN_LOG2 = 6,
  parameter int HYST     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_error,
  input  logic                    i_ovr,
  input  logic                    i_clear,
  input  logic        [WIDTH-1:0] i_conv_thresh,
  input  logic        [WIDTH-1:0] i_div_thresh,
  output logic        [WIDTH-1:0] o_mse,
  output logic                    o_mse_valid,
  output logic        [1:0]       o_state,
  output logic        [CNT_W-1:0] o_ovr_count
);
  localparam int ACC_W = WIDTH + WIN_LOG2;
  localparam logic [CNT_W-1:0] HYST_C = CNT_W'(HYST);

  state_t               state;
  logic                 take;
  logic                 s1_vld, s1_ovr;
  logic [WIDTH-1:0]     sq;
  logic [ACC_W-1:0]     acc, sum_nxt;
  logic [WIN_LOG2-1:0]  cnt;
  logic                 win_ovr;
  logic                 done, done_ovr;
  logic [WIDTH-1:0]     done_mse;
  logic                 pass, fail_div;
  logic [CNT_W-1:0]     run, run_nxt;

  // A sample that arrives together with a clear is dropped.
  assign take    = i_valid & ~i_clear;
  assign sum_nxt = acc + {{WIN_LOG2{1'b0}}, sq};
  assign o_state = state;

  // Evaluation uses the thresholds present in the evaluation cycle.
  assign pass     = (done_mse < i_conv_thresh) && !done_ovr;
  assign fail_div = (done_mse > i_div_thresh) || done_ovr;
  assign run_nxt  = run + CNT_W'(1);

  err_square #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sq (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .en    (take),
    .error (i_error),
    .sq    (sq)
  );

  // Valid and overflow tag travelling alongside the square register.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      s1_vld <= 1'b0;
      s1_ovr <= 1'b0;
    end else begin
      s1_vld <= take;
      s1_ovr <= take & i_ovr;
    end
  end

  // Saturating overflow counter; survives clear, only reset zeroes it.
  always_ff @(posedge clk) begin
    if (rst)
      o_ovr_count <= '0;
    else if (take && i_ovr && (o_ovr_count != '1))
      o_ovr_count <= o_ovr_count + CNT_W'(1);
  end

  // Window accumulator; on the last sample the total is handed off and the
  // accumulator restarts at zero so the next sample lands in a fresh window.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      acc      <= '0;
      cnt      <= '0;
      win_ovr  <= 1'b0;
      done     <= 1'b0;
      done_ovr <= 1'b0;
      done_mse <= '0;
    end else begin
      done <= 1'b0;
      if (s1_vld) begin
        if (cnt == '1) begin
          done     <= 1'b1;
          done_mse <= WIDTH'(sum_nxt >> WIN_LOG2);
          done_ovr <= win_ovr | s1_ovr;
          acc      <= '0;
          cnt      <= '0;
          win_ovr  <= 1'b0;
        end else begin
          acc     <= sum_nxt;
          cnt     <= cnt + WIN_LOG2'(1);
          win_ovr <= win_ovr | s1_ovr;
        end
      end
    end
  end

  // Output register and convergence FSM, advanced once per completed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_mse       <= '0;
      o_mse_valid <= 1'b0;
      state       <= ACQUIRE;
      run         <= '0;
    end else if (i_clear) begin
      o_mse_valid <= 1'b0;
      state       <= ACQUIRE;
      run         <= '0;
    end else begin
      o_mse_valid <= done;
      if (done) begin
        o_mse <= done_mse;
        case (state)
          ACQUIRE: begin
            if (fail_div) begin
              state <= DIVERGED;
              run   <= '0;
            end else if (pass) begin
              if (run_nxt >= HYST_C) begin
                state <= CONVERGED;
                run   <= '0;
              end else
                run <= run_nxt;
            end else
              run <= '0;
          end
          CONVERGED: begin
            if (fail_div) begin
              state <= DIVERGED;
              run   <= '0;
            end else if (!pass) begin
              if (run_nxt >= HYST_C) begin
                state <= ACQUIRE;
                run   <= '0;
              end else
                run <= run_nxt;
            end else
              run <= '0;
          end
          default: run <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_error_monitor.sv
// Directed bench for error_monitor (WIDTH=32, FRAC=20, WIN_LOG2=2, HYST=2).
module tb_error_monitor;
  localparam logic [31:0] HALF  = 32'h0008_0000;
  localparam logic [31:0] NEG4  = 32'hFFC0_0000;
  localparam logic [31:0] BIG   = 32'h7FFF_FFFF;
  localparam logic [31:0] MSE_H = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_error = '0;
  logic        i_ovr = 1'b0;
  logic        i_clear = 1'b0;
  logic [31:0] i_conv_thresh = 32'h0010_0000;
  logic [31:0] i_div_thresh  = 32'h00A0_0000;
  logic [31:0] o_mse;
  logic        o_mse_valid;
  logic [1:0]  o_state;
  logic [15:0] o_ovr_count;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [31:0] last_mse = '0;

  error_monitor #(.WIDTH(32), .FRAC(20), .WIN_LOG2(2), .HYST(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_error       (i_error),
    .i_ovr         (i_ovr),
    .i_clear       (i_clear),
    .i_conv_thresh (i_conv_thresh),
    .i_div_thresh  (i_div_thresh),
    .o_mse         (o_mse),
    .o_mse_valid   (o_mse_valid),
    .o_state       (o_state),
    .o_ovr_count   (o_ovr_count)
  );

  always #5 clk = ~clk;

  // Pulse recorder: every high cycle of o_mse_valid counts once.
  always @(negedge clk) begin
    if (o_mse_valid) begin
      pulses++;
      last_mse = o_mse;
    end
  end

  task automatic drive(input logic v, input logic [31:0] e, input logic o, input logic c);
    @(negedge clk);
    i_valid = v; i_error = e; i_ovr = o; i_clear = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic send4(input logic [31:0] e);
    repeat (4) drive(1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    chk("reset_mse", o_mse, 32'h0);
    chk("reset_valid", {31'b0, o_mse_valid}, 32'h0);
    chk("reset_state", {30'b0, o_state}, 32'h0);
    chk("reset_ovr", {16'b0, o_ovr_count}, 32'h0);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_converge();
    int p0;
    p0 = pulses;
    send4(HALF);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("latency_early", {31'b0, o_mse_valid}, 32'h0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("latency_pulse", {31'b0, o_mse_valid}, 32'h1);
    chk("conv_mse1", o_mse, MSE_H);
    chk("conv_state1", {30'b0, o_state}, 32'd0);
    send4(HALF);
    idle(4);
    chk("conv_pulses", pulses - p0, 32'd2);
    chk("conv_mse2", last_mse, MSE_H);
    chk("conv_state2", {30'b0, o_state}, 32'd1);
  endtask

  task automatic test_diverge();
    send4(NEG4);
    idle(4);
    chk("div_mse", o_mse, 32'h0100_0000);
    chk("div_state", {30'b0, o_state}, 32'd2);
    send4(HALF);
    idle(4);
    chk("div_hold", {30'b0, o_state}, 32'd2);
    do_clear();
    chk("div_clear", {30'b0, o_state}, 32'd0);
  endtask

  task automatic test_saturate();
    send4(BIG);
    idle(4);
    chk("sat_mse", o_mse, 32'hFFFF_FFFF);
    chk("sat_state", {30'b0, o_state}, 32'd2);
    do_clear();
  endtask

  task automatic test_ovr();
    drive(1'b1, HALF, 1'b0, 1'b0);
    drive(1'b1, HALF, 1'b1, 1'b0);
    drive(1'b1, HALF, 1'b0, 1'b0);
    drive(1'b1, HALF, 1'b0, 1'b0);
    idle(4);
    chk("ovr_count", {16'b0, o_ovr_count}, 32'd1);
    chk("ovr_mse", o_mse, MSE_H);
    chk("ovr_state", {30'b0, o_state}, 32'd2);
    do_clear();
    chk("ovr_retain", {16'b0, o_ovr_count}, 32'd1);
    chk("mse_retain", o_mse, MSE_H);
  endtask

  task automatic test_toggle();
    int p0;
    p0 = pulses;
    repeat (8) begin
      drive(1'b1, HALF, 1'b0, 1'b0);
      drive(1'b0, NEG4, 1'b0, 1'b0);
    end
    idle(4);
    chk("tog_pulses", pulses - p0, 32'd2);
    chk("tog_mse", last_mse, MSE_H);
    chk("tog_state", {30'b0, o_state}, 32'd1);
    // Clear lands on the edge that would register the window-end pulse.
    send4(HALF);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(4);
    chk("clr_nopulse", pulses - p0, 32'd2);
    chk("clr_state", {30'b0, o_state}, 32'd0);
  endtask

  task automatic test_equal();
    int p0;
    p0 = pulses;
    i_conv_thresh = MSE_H;
    i_div_thresh  = MSE_H;
    send4(HALF);
    send4(HALF);
    idle(4);
    chk("eq_pulses", pulses - p0, 32'd2);
    chk("eq_state", {30'b0, o_state}, 32'd0);
    i_conv_thresh = 32'h0010_0000;
    i_div_thresh  = 32'h00A0_0000;
  endtask

  task automatic test_reset_mid();
    int p0;
    repeat (3) drive(1'b1, NEG4, 1'b0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rmid_mse", o_mse, 32'h0);
    chk("rmid_state", {30'b0, o_state}, 32'd0);
    chk("rmid_ovr", {16'b0, o_ovr_count}, 32'd0);
    p0 = pulses;
    repeat (3) drive(1'b1, HALF, 1'b0, 1'b0);
    idle(4);
    chk("rmid_nopulse", pulses - p0, 32'd0);
    drive(1'b1, HALF, 1'b0, 1'b0);
    idle(4);
    chk("rmid_pulse", pulses - p0, 32'd1);
    chk("rmid_newmse", last_mse, MSE_H);
  endtask

  initial begin
    test_reset();
    test_converge();
    test_diverge();
    test_saturate();
    test_ovr();
    test_toggle();
    test_equal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
